// File: rtl/riscv_mem_pkg.sv
// Shared encodings for the unified-memory port arbiter: transaction FSM
// states, access owner, and grant one-hot bit positions.
package riscv_mem_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } arbState_t;

   typedef enum logic {
      OWN_IF = 1'b0,
      OWN_DM = 1'b1
   } owner_t;

   localparam int GRANT_IF = 0;
   localparam int GRANT_DM = 1;

endpackage

// File: rtl/mem_arb_grant.sv
// Fetch/data priority decision with a bounded anti-starvation streak for fetch.
// Grants are only produced while the idle qualifier is high.
module mem_arb_grant
   import riscv_mem_pkg::*;
#(
   parameter int STARVE_MAX = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       if_req,
   input  logic       dm_req,
   input  logic       if_flush,
   input  logic       idle,
   output logic [1:0] grant
);

   localparam int STREAK_W = $clog2(STARVE_MAX + 1);
   localparam logic [STREAK_W-1:0] STREAK_LIMIT = STREAK_W'(STARVE_MAX);

   logic [STREAK_W-1:0] streak;
   logic                fetchWins;

   // NOTE: every output of a combinational block gets a default first so no latch is inferred.
   always_comb begin
      grant     = '0;
      fetchWins = if_req & ~if_flush & (~dm_req | (streak == STREAK_LIMIT));
      grant[GRANT_IF] = idle & fetchWins;
      grant[GRANT_DM] = idle & dm_req & ~fetchWins;
   end

   // A flushed fetch at the limit lets data through; saturating keeps the streak meaningful.
   always_ff @(posedge clk) begin
      // NOTE: state is updated with non-blocking assignments so all flops see pre-edge values.
      if (rst) begin
         streak <= '0;
      end else if (idle) begin
         if (!if_req || grant[GRANT_IF]) begin
            streak <= '0;
         end else if (grant[GRANT_DM] && (streak != STREAK_LIMIT)) begin
            streak <= streak + STREAK_W'(1);
         end
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Serialises fetch and data accesses onto the single-ported unified memory
// with a fixed-latency IDLE/WAIT/RESP transaction FSM.
module mem_port_arbiter
   import riscv_mem_pkg::*;
#(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter int MEM_LAT    = 2,
   parameter int STARVE_MAX = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   input  logic              if_flush,
   output logic              if_valid,
   output logic [DATA_W-1:0] if_rdata,
   input  logic              dm_req,
   input  logic              dm_we,
   input  logic [ADDR_W-1:0] dm_addr,
   input  logic [DATA_W-1:0] dm_wdata,
   output logic              dm_valid,
   output logic [DATA_W-1:0] dm_rdata,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);

   localparam int CNT_W = $clog2(MEM_LAT + 1);
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LAT - 1);

   arbState_t        state;
   arbState_t        nextState;
   logic [CNT_W-1:0] cnt;
   owner_t           owner;
   logic             cancelled;
   logic             idle;
   logic             anyGrant;
   logic             respActive;
   logic [1:0]       grant;

   // Gating with rst keeps every output at 0 even if reset lands mid-transaction.
   assign idle     = (state == IDLE) & ~rst;
   assign anyGrant = |grant;

   mem_arb_grant #(
      .STARVE_MAX (STARVE_MAX)
   ) grantUnit (
      .clk      (clk),
      .rst      (rst),
      .if_req   (if_req),
      .dm_req   (dm_req),
      .if_flush (if_flush),
      .idle     (idle),
      .grant    (grant)
   );

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= nextState;
   end

   always_comb begin
      nextState = state;
      case (state)
         IDLE:    if (anyGrant) nextState = (MEM_LAT == 1) ? RESP : WAIT;
         WAIT:    if (cnt == CNT_W'(1)) nextState = RESP;
         RESP:    nextState = IDLE;
         default: nextState = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt       <= '0;
         owner     <= OWN_IF;
         cancelled <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               cnt       <= CNT_LOAD;
               cancelled <= 1'b0;
               if (anyGrant) owner <= grant[GRANT_DM] ? OWN_DM : OWN_IF;
            end
            WAIT: begin
               cnt <= cnt - CNT_W'(1);
               if (if_flush && (owner == OWN_IF)) cancelled <= 1'b1;
            end
            default: cancelled <= 1'b0;
         endcase
      end
   end

   // A flush arriving in the RESP cycle itself suppresses the pulse directly.
   always_comb begin
      mem_en     = anyGrant;
      mem_we     = grant[GRANT_DM] & dm_we;
      mem_addr   = '0;
      mem_wdata  = '0;
      if (grant[GRANT_DM]) begin
         mem_addr  = dm_addr;
         mem_wdata = dm_wdata;
      end else if (grant[GRANT_IF]) begin
         mem_addr  = if_addr;
      end
      respActive = (state == RESP) & ~rst;
      if_valid   = respActive & (owner == OWN_IF) & ~cancelled & ~if_flush;
      dm_valid   = respActive & (owner == OWN_DM);
      if_rdata   = if_valid ? mem_rdata : '0;
      dm_rdata   = dm_valid ? mem_rdata : '0;
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a latency-accurate memory model
// and a response scoreboard popped on every observed valid pulse.
module tb_mem_port_arbiter;

   localparam int ADDR_W     = 32;
   localparam int DATA_W     = 32;
   localparam int MEM_LAT    = 2;
   localparam int STARVE_MAX = 4;

   logic              clk = 1'b0;
   logic              rst;
   logic              if_req;
   logic [ADDR_W-1:0] if_addr;
   logic              if_flush;
   logic              if_valid;
   logic [DATA_W-1:0] if_rdata;
   logic              dm_req;
   logic              dm_we;
   logic [ADDR_W-1:0] dm_addr;
   logic [DATA_W-1:0] dm_wdata;
   logic              dm_valid;
   logic [DATA_W-1:0] dm_rdata;
   logic              mem_en;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;

   typedef struct {
      logic        isIf;
      logic        checkData;
      logic [31:0] data;
   } resp_t;

   resp_t sb[$];
   int    total = 0;
   int    bad   = 0;
   int    cyc   = 0;

   mem_port_arbiter #(
      .ADDR_W     (ADDR_W),
      .DATA_W     (DATA_W),
      .MEM_LAT    (MEM_LAT),
      .STARVE_MAX (STARVE_MAX)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .if_req    (if_req),
      .if_addr   (if_addr),
      .if_flush  (if_flush),
      .if_valid  (if_valid),
      .if_rdata  (if_rdata),
      .dm_req    (dm_req),
      .dm_we     (dm_we),
      .dm_addr   (dm_addr),
      .dm_wdata  (dm_wdata),
      .dm_valid  (dm_valid),
      .dm_rdata  (dm_rdata),
      .mem_en    (mem_en),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata)
   );

   always #5 clk = ~clk;

   // Unwritten locations hold an address-derived pattern; 0x40 is preloaded.
   function automatic logic [31:0] defaultWord(input logic [31:0] a);
      return (a == 32'h40) ? 32'hDEAD_BEEF : {a[15:0] ^ 16'hC3A5, a[15:0]};
   endfunction

   // Memory model: read data appears MEM_LAT (=2) cycles after the mem_en cycle.
   logic [31:0] memStore [logic [31:0]];
   logic [31:0] rd1;
   logic [31:0] rd2;
   assign mem_rdata = rd2;

   always @(posedge clk) begin
      if (mem_en && mem_we) memStore[mem_addr] = mem_wdata;
      rd2 <= rd1;
      if (mem_en && !mem_we)
         rd1 <= memStore.exists(mem_addr) ? memStore[mem_addr] : defaultWord(mem_addr);
      else
         rd1 <= 32'h0BAD_F00D;
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   function automatic logic anyOut();
      return |{if_valid, dm_valid, mem_en, mem_we, mem_addr, mem_wdata, if_rdata, dm_rdata};
   endfunction

   task automatic pushResp(input logic isIf, input logic checkData, input logic [31:0] data);
      resp_t e;
      e.isIf      = isIf;
      e.checkData = checkData;
      e.data      = data;
      sb.push_back(e);
   endtask

   // Sample point: mid-cycle, after inputs settled and before the next edge.
   task automatic half();
      @(negedge clk);
      if (if_valid || dm_valid) begin
         if (sb.size() == 0) begin
            check("sb_unexpected_valid", {62'b0, if_valid, dm_valid}, 64'd0);
         end else begin
            resp_t e;
            e = sb.pop_front();
            check("resp_owner", {62'b0, if_valid, dm_valid}, e.isIf ? 64'd2 : 64'd1);
            if (e.checkData) check("resp_data", e.isIf ? if_rdata : dm_rdata, e.data);
         end
      end
   endtask

   task automatic adv();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic step();
      half();
      adv();
   endtask

   task automatic expectGrant(input string tag, input logic [31:0] addr, input logic we);
      check({tag, "_en"}, mem_en, 1);
      check({tag, "_addr"}, mem_addr, addr);
      check({tag, "_we"}, mem_we, we);
   endtask

   initial begin
      rst = 1'b1; if_req = 1'b0; if_addr = '0; if_flush = 1'b0;
      dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h44; dm_wdata = '0;

      // Reset with a pending data request: nothing may leak out.
      repeat (2) begin
         half(); check("rst_outputs_zero", anyOut(), 0); adv();
      end
      rst = 1'b0; dm_req = 1'b0;
      step();

      // Single load from 0x40.
      dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h40;
      half(); expectGrant("ld_grant", 32'h40, 1'b0); pushResp(1'b0, 1'b1, 32'hDEAD_BEEF); adv();
      half(); check("ld_wait_en", mem_en, 0); check("ld_wait_valid", dm_valid, 0); adv();
      half(); check("ld_resp_valid", dm_valid, 1); check("ld_resp_data", dm_rdata, 32'hDEAD_BEEF);
      check("ld_resp_no_grant", mem_en, 0); check("ld_if_valid", if_valid, 0); adv();
      dm_req = 1'b0;
      half(); check("ld_after", {dm_valid, mem_en}, 0); adv();

      // Simultaneous requests: data first, fetch three cycles later.
      if_req = 1'b1; if_addr = 32'h100; dm_req = 1'b1; dm_addr = 32'h48;
      half(); expectGrant("sim_dm", 32'h48, 1'b0); pushResp(1'b0, 1'b1, defaultWord(32'h48)); adv();
      step();
      half(); check("sim_dm_valid", dm_valid, 1); check("sim_if_not_yet", if_valid, 0); adv();
      dm_req = 1'b0;
      half(); expectGrant("sim_if", 32'h100, 1'b0); pushResp(1'b1, 1'b1, defaultWord(32'h100)); adv();
      step();
      half(); check("sim_if_valid", if_valid, 1); adv();
      if_req = 1'b0;
      step();

      // Starvation bound: four data grants, then fetch, then the streak restarts.
      if_req = 1'b1; if_addr = 32'h200; dm_req = 1'b1; dm_addr = 32'h50;
      for (int k = 0; k < 10; k++) begin
         logic        isF;
         logic [31:0] expAddr;
         isF     = (k == 4) || (k == 9);
         expAddr = isF ? 32'h200 : 32'h50;
         half(); expectGrant($sformatf("starve_g%0d", k), expAddr, 1'b0);
         pushResp(isF, 1'b1, defaultWord(expAddr)); adv();
         half(); check($sformatf("starve_wait%0d", k), mem_en, 0); adv();
         half(); check($sformatf("starve_resp%0d", k), {if_valid, dm_valid}, isF ? 2'b10 : 2'b01);
         check($sformatf("starve_resp_en%0d", k), mem_en, 0); adv();
      end
      if_req = 1'b0; dm_req = 1'b0;
      step();

      // Flush while the fetch is in WAIT.
      if_req = 1'b1; if_addr = 32'h300;
      half(); expectGrant("fl_grant", 32'h300, 1'b0); adv();
      if_flush = 1'b1; if_addr = 32'h340;
      half(); check("fl_wait_en", mem_en, 0); adv();
      if_flush = 1'b0;
      half(); check("fl_no_valid", if_valid, 0); check("fl_resp_en", mem_en, 0); adv();
      half(); expectGrant("fl_regrant", 32'h340, 1'b0); pushResp(1'b1, 1'b1, defaultWord(32'h340)); adv();
      step();
      half(); check("fl_new_valid", if_valid, 1); adv();

      // Flush in IDLE blocks the fetch grant for that cycle only.
      if_addr = 32'h380; if_flush = 1'b1;
      half(); check("fli_blocked", mem_en, 0); adv();
      if_flush = 1'b0;
      half(); expectGrant("fli_grant", 32'h380, 1'b0); pushResp(1'b1, 1'b1, defaultWord(32'h380)); adv();
      step();
      half(); check("fli_valid", if_valid, 1); adv();
      if_req = 1'b0;
      step();

      // Store then load back through the memory model.
      dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h80; dm_wdata = 32'h1234_5678;
      half(); expectGrant("st_grant", 32'h80, 1'b1); check("st_wdata", mem_wdata, 32'h1234_5678);
      pushResp(1'b0, 1'b0, 32'h0); adv();
      half(); check("st_wait_bus", {mem_en, mem_we, |mem_addr, |mem_wdata}, 0); adv();
      half(); check("st_valid", dm_valid, 1); check("st_resp_we", mem_we, 0); adv();
      dm_we = 1'b0; dm_wdata = '0;
      half(); expectGrant("ldst_grant", 32'h80, 1'b0); pushResp(1'b0, 1'b1, 32'h1234_5678); adv();
      step();
      half(); check("ldst_valid", dm_valid, 1); check("ldst_data", dm_rdata, 32'h1234_5678); adv();
      dm_req = 1'b0;
      step();

      // Reset during WAIT: response discarded, first post-reset cycle grants.
      dm_req = 1'b1; dm_addr = 32'h60;
      half(); expectGrant("rw_grant", 32'h60, 1'b0); adv();
      rst = 1'b1;
      half(); check("rw_rst_zero1", anyOut(), 0); adv();
      dm_addr = 32'h64;
      half(); check("rw_rst_zero2", anyOut(), 0); adv();
      rst = 1'b0;
      half(); expectGrant("rw_first_grant", 32'h64, 1'b0); pushResp(1'b0, 1'b1, defaultWord(32'h64)); adv();
      half(); check("rw_no_stale", {if_valid, dm_valid}, 0); adv();
      half(); check("rw_valid", dm_valid, 1); adv();
      dm_req = 1'b0;
      repeat (3) step();

      check("sb_empty", sb.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
